bcd_entry_ctrl: RTL and testbench
=================================

# bcd_entry_ctrl

Keypad operand-entry controller for the calculator datapath. It turns single-key events into a sign-plus-3-digit BCD operand, drives the live entry to the display, and hands the finished operand downstream over a valid/ready handshake. It instantiates the existing `bcdtobin` converter, so the operand is also presented in binary.

## Interface
- No parameters. Digit count is fixed at 3 and the sign sits in nibble 3, to match the `bcdtobin` format.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: one-cycle key event strobe.
- `key_code` in 4: 0–9 digit; 0xA negate-toggle; 0xB backspace; 0xC clear; 0xD enter; 0xE/0xF ignored.
- `key_ready` out 1: controller accepts keys (high in ENTRY, low in SEND).
- `key_reject` out 1: one-cycle pulse when a key event is refused.
- `disp_bcd` out 32: live entry for the 7-segment display.
- `digit_count` out 2: number of digits entered, 0–3.
- `op_valid` out 1: operand available.
- `op_ready` in 1: downstream accepts the operand.
- `op_bcd` out 32: operand as {16'hFFFF, sign, hundreds, tens, ones}.
- `op_bin` out 11 (signed): `bcdtobin(op_bcd)`, combinational.

## Operation
- **Nibble codes**: 0–9 is a digit, 0xE is minus, 0xF is blank. Unused digit positions and nibbles 7..4 are always blank. The sign nibble is 0xE when `neg` is set, else 0xF.
- **FSM states**:
  - ENTRY: the default state after reset.
  - SEND: entered on an accepted enter key. Returns to ENTRY on the `op_valid && op_ready` edge.
- **Key actions in ENTRY**, all effective at the next clock edge:
  - Digit with count<3:
    - If count==1 and ones==0, replace ones (no leading zeros).
    - Otherwise shift left (hundreds←tens, tens←ones, ones←digit) and increment count.
  - Digit with count==3: refused; pulse `key_reject`.
  - Negate: toggle `neg`. Allowed at any count.
  - Backspace with count>0: shift right (ones←tens, tens←hundreds, hundreds←0xF) and decrement count. `neg` is kept.
  - Backspace with count==0: refused.
  - Clear: all digits blank, count 0, `neg` 0. Never refused.
  - Enter with count>0: latch `op_bcd` from the entry, go to SEND, clear the entry.
  - Enter with count==0: refused, including the "-" only case.
  - Codes 0xE/0xF: ignored with no reject pulse.
- **SEND**:
  - `op_valid`=1 and `op_bcd` is held stable until the handshake completes.
  - Any `key_valid` is refused (`key_reject` pulses) and has no other effect.
  - `disp_bcd` shows the blank entry.
- **Range**: maximum magnitude 999 fits 11-bit signed. "-0" yields `op_bin`=0; this is legal.

## Timing
- **Reset values**:
  - `disp_bcd` and `op_bcd` = 0xFFFF_FFFF.
  - `digit_count`=0, `op_valid`=0, `key_reject`=0, `key_ready`=1.
  - State = ENTRY.
- **Key latency**: one cycle. A key sampled at edge N is visible on `disp_bcd`/`digit_count` after edge N, and `key_reject` is high for the cycle after edge N.
- **Enter**: `op_valid` rises in the cycle after the edge that samples enter. `key_ready` falls in that same cycle.
- **Handshake**:
  - Transfer happens on an edge where `op_valid && op_ready`. `op_valid` is low in the following cycle and `key_ready` is high again.
  - `op_ready` high before `op_valid` gives a one-cycle SEND.
  - `op_valid` is never withdrawn without a transfer, except by `rst`.
- **Reset mid-operation**: `rst` wins over all keys and over the handshake. It drops `op_valid` after the edge, even if `op_ready` was high.
- `key_reject` never stays high for two cycles from one event; back-to-back refused keys give back-to-back pulses.

## Structure
- Shared package `calc_pkg` holds:
  - Key codes: `KEY_NEG`, `KEY_BKSP`, `KEY_CLR`, `KEY_ENT`.
  - Nibble codes: `NIB_MINUS`=4'hE, `NIB_BLANK`=4'hF.
  - The state enum {ENTRY, SEND}.
- The only sub-module is one `bcdtobin` instance on `op_bcd`. The entry register and FSM stay in this module.

## Test plan
- Keys 1,2,3,enter with `op_ready`=1 → `op_bcd`=0xFFFFF123, `op_bin`=123, `op_valid` high exactly 1 cycle, then `disp_bcd`=0xFFFFFFFF.
- Keys 4,5,negate,enter with `op_ready` low for 3 cycles:
  - `op_bcd`=0xFFFFEF45 and `op_bin`=-45, held stable for all 4 cycles.
  - A digit key during SEND → `key_reject` pulse and no change.
- Keys 9,9,9,7 → 4th key rejected, `disp_bcd`=0xFFFFF999, `digit_count`=3.
- Keys 0,0,7 → `disp_bcd`=0xFFFFFFF7, `digit_count`=1. Then backspace → `disp_bcd` all blank, count 0.
- Backspace, then enter, on an empty entry → two `key_reject` pulses, `op_valid` stays 0. Then clear → no reject.
- Keys 8,enter, then `rst` for 1 cycle while `op_ready`=1 → `op_valid`=0 and all outputs at reset values after the edge. No transfer is counted.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes, nibble codes and entry FSM states for the calculator.
package calc_pkg;
  localparam logic [3:0] KEY_NEG = 4'hA;
  localparam logic [3:0] KEY_BKSP = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hD;
  localparam logic [3:0] NIB_MINUS = 4'hE;
  localparam logic [3:0] NIB_BLANK = 4'hF;
  typedef enum logic {ENTRY = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/bcdtobin.sv
// bcdtobin: sign-plus-3-digit BCD (blank digits read as 0) to 11-bit signed binary.
module bcdtobin
  import calc_pkg::*;
(
  input  logic [31:0]        bcd_i,
  output logic signed [10:0] bin_o
);
  function automatic logic [9:0] dv(input logic [3:0] n);
    return n > 4'd9 ? 10'd0 : {6'd0, n};
  endfunction
  logic [9:0] mag;
  always_comb begin
    mag = dv(bcd_i[11:8]) * 10'd100 + dv(bcd_i[7:4]) * 10'd10 + dv(bcd_i[3:0]);
    bin_o = bcd_i[15:12] == NIB_MINUS ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end
endmodule

// File: rtl/bcd_entry_ctrl.sv
// bcd_entry_ctrl: keypad operand entry into sign+3-digit BCD with valid/ready hand-off.
module bcd_entry_ctrl
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  output logic               key_ready,
  output logic               key_reject,
  output logic [31:0]        disp_bcd,
  output logic [1:0]         digit_count,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [31:0]        op_bcd,
  output logic signed [10:0] op_bin
);
  state_e state_q, state_d;
  logic [3:0] h_q, t_q, o_q, h_d, t_d, o_d;
  logic [1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rej_q, rej_d;
  logic [31:0] op_q, op_d, entry;
  always_comb begin
    entry = {16'hFFFF, neg_q ? NIB_MINUS : NIB_BLANK, h_q, t_q, o_q};
    state_d = state_q;
    {h_d, t_d, o_d, cnt_d, neg_d, op_d} = {h_q, t_q, o_q, cnt_q, neg_q, op_q};
    rej_d = 1'b0;
    if (state_q == SEND) begin
      rej_d = key_valid;
      state_d = op_ready ? ENTRY : SEND;
    end else if (key_valid) begin
      if (key_code <= 4'd9) begin
        if (cnt_q == 2'd3) rej_d = 1'b1;
        else if (cnt_q == 2'd1 && o_q == 4'd0) o_d = key_code;
        else {h_d, t_d, o_d, cnt_d} = {t_q, o_q, key_code, cnt_q + 2'd1};
      end else if (key_code == KEY_NEG) begin
        neg_d = ~neg_q;
      end else if (key_code == KEY_BKSP) begin
        if (cnt_q == 2'd0) rej_d = 1'b1;
        else {h_d, t_d, o_d, cnt_d} = {NIB_BLANK, h_q, t_q, cnt_q - 2'd1};
      end else if (key_code == KEY_CLR || (key_code == KEY_ENT && cnt_q != 2'd0)) begin
        {h_d, t_d, o_d, cnt_d, neg_d} = {NIB_BLANK, NIB_BLANK, NIB_BLANK, 2'd0, 1'b0};
        op_d = key_code == KEY_ENT ? entry : op_q;
        state_d = key_code == KEY_ENT ? SEND : ENTRY;
      end else if (key_code == KEY_ENT) begin
        rej_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      {h_q, t_q, o_q} <= {NIB_BLANK, NIB_BLANK, NIB_BLANK};
      cnt_q <= 2'd0;
      neg_q <= 1'b0;
      rej_q <= 1'b0;
      op_q <= 32'hFFFF_FFFF;
    end else begin
      state_q <= state_d;
      {h_q, t_q, o_q} <= {h_d, t_d, o_d};
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      rej_q <= rej_d;
      op_q <= op_d;
    end
  end
  assign key_ready = state_q == ENTRY;
  assign op_valid = state_q == SEND;
  assign key_reject = rej_q;
  assign disp_bcd = entry;
  assign digit_count = cnt_q;
  assign op_bcd = op_q;
  bcdtobin u_b2b (.bcd_i(op_q), .bin_o(op_bin));
endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// tb_bcd_entry_ctrl: directed plus random keys against a digit-list model; operands scoreboarded.
module tb_bcd_entry_ctrl;
  logic clk, rst, key_valid, op_ready;
  logic [3:0] key_code;
  logic key_ready, key_reject, op_valid;
  logic [31:0] disp_bcd, op_bcd;
  logic [1:0] digit_count;
  logic signed [10:0] op_bin;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] bcd; int bin;} op_t;
  op_t sb[$];
  int dig[$];
  bit m_neg, m_send, m_rej;
  logic [31:0] m_last;
  int m_last_bin;

  bcd_entry_ctrl dut (.clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .key_reject(key_reject), .disp_bcd(disp_bcd),
    .digit_count(digit_count), .op_valid(op_valid), .op_ready(op_ready),
    .op_bcd(op_bcd), .op_bin(op_bin));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cur_bcd();
    logic [31:0] r = 32'hFFFF_FFFF;
    r[15:12] = m_neg ? 4'hE : 4'hF;
    for (int i = 0; i < dig.size(); i++) r[4*i +: 4] = 4'(dig[dig.size()-1-i]);
    return r;
  endfunction

  function automatic int cur_val();
    int v = 0;
    foreach (dig[i]) v = v * 10 + dig[i];
    return m_neg ? -v : v;
  endfunction

  task automatic model(input bit r, input bit kv, input logic [3:0] kc, input bit ordy);
    if (r) begin
      dig.delete(); sb.delete();
      m_neg = 0; m_send = 0; m_rej = 0;
      m_last = 32'hFFFF_FFFF; m_last_bin = 0;
    end else begin
      m_rej = 0;
      if (m_send) begin
        m_rej = kv;
        if (ordy) m_send = 0;
      end else if (kv) begin
        if (kc < 10) begin
          if (dig.size() == 3) m_rej = 1;
          else if (dig.size() == 1 && dig[0] == 0) dig[0] = int'(kc);
          else dig.push_back(int'(kc));
        end else if (kc == 4'hA) m_neg = !m_neg;
        else if (kc == 4'hB) begin
          if (dig.size() == 0) m_rej = 1;
          else void'(dig.pop_back());
        end else if (kc == 4'hC) begin
          dig.delete(); m_neg = 0;
        end else if (kc == 4'hD) begin
          if (dig.size() == 0) m_rej = 1;
          else begin
            m_last = cur_bcd(); m_last_bin = cur_val();
            sb.push_back('{m_last, m_last_bin});
            m_send = 1; dig.delete(); m_neg = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit kv, input logic [3:0] kc, input bit ordy);
    rst = r; key_valid = kv; key_code = kc; op_ready = ordy;
    @(posedge clk);
    model(r, kv, kc, ordy);
    #1;
    chk("disp_bcd", disp_bcd, cur_bcd());
    chk("digit_count", 32'(digit_count), 32'(dig.size()));
    chk("key_reject", 32'(key_reject), 32'(m_rej));
    chk("key_ready", 32'(key_ready), 32'(!m_send));
    chk("op_valid", 32'(op_valid), 32'(m_send));
    chk("op_bcd_hold", op_bcd, m_last);
    chk("op_bin_hold", 32'(int'(op_bin)), 32'(m_last_bin));
  endtask

  always @(negedge clk) begin
    if (!rst && op_valid && op_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer: unexpected transfer op_bcd=%h expected none", op_bcd);
      end else begin
        chk("xfer_op_bcd", op_bcd, sb[0].bcd);
        chk("xfer_op_bin", 32'(int'(op_bin)), 32'(sb[0].bin));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    bit r, kv, ordy;
    logic [3:0] kc;
    rst = 1; key_valid = 0; key_code = 0; op_ready = 0;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 1); cyc(0, 1, 2, 1); cyc(0, 1, 3, 1); cyc(0, 1, 4'hD, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 1, 4, 0); cyc(0, 1, 5, 0); cyc(0, 1, 4'hA, 0); cyc(0, 1, 4'hD, 0);
    cyc(0, 0, 0, 0); cyc(0, 1, 7, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(0, 1, 9, 0); cyc(0, 1, 9, 0); cyc(0, 1, 9, 0); cyc(0, 1, 7, 0);
    cyc(0, 1, 4'hC, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 7, 0); cyc(0, 1, 4'hB, 0);
    cyc(0, 1, 4'hB, 0); cyc(0, 1, 4'hD, 0); cyc(0, 1, 4'hC, 0); cyc(0, 1, 4'hE, 0);
    cyc(0, 1, 8, 1); cyc(0, 1, 4'hD, 0); cyc(1, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 1, 4'hA, 0); cyc(0, 1, 4'hD, 0); cyc(0, 1, 0, 1); cyc(0, 1, 4'hD, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199) == 0;
      kv = $urandom_range(0, 1) == 1;
      kc = $urandom_range(0, 3) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ordy = $urandom_range(0, 3) != 0;
      cyc(r, kv, kc, ordy);
    end
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
